video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Video source that drives the rx_* pixel stream consumed by hdmi_buffer.
//  Generates raster timing (active/front porch/sync/back porch, H and V) with
//  selectable test patterns, so the buffer and median filter run without an HDMI receiver.
//  One pixel per clk; all outputs registered.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch, cycles
//  H_SYNC    40    hsync width, cycles
//  H_BP      220   horizontal back porch, cycles
//  V_ACTIVE  720   active lines per frame
//  V_FP      5     vertical front porch, lines
//  V_SYNC    5     vsync width, lines
//  V_BP      20    vertical back porch, lines
//  BAR_W     160   colour-bar width in pixels (8 bars)
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous reset, active-high
//  en           in   1   run; 0 = blank outputs and rewind raster
//  pattern_sel  in   2   0 solid, 1 colour bars, 2 gradient, 3 moving checkerboard
//  const_red    in   8   solid-pattern red
//  const_green  in   8   solid-pattern green
//  const_blue   in   8   solid-pattern blue
//  tx_red       out  8   pixel red
//  tx_green     out  8   pixel green
//  tx_blue      out  8   pixel blue
//  tx_dv        out  1   pixel valid (active region)
//  tx_hs        out  1   hsync, active-high
//  tx_vs        out  1   vsync, active-high
//  frame_start  out  1   1-cycle pulse with first active pixel of each frame
// BEHAVIOUR
//  - Counters h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, same for V.
//    Widths $clog2(total). h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 and increments frame_cnt (8b, wraps).
//  - Regions: active h<H_ACTIVE; hsync H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; same scheme for v.
//  - Outputs registered from current counters: 1-cycle latency. tx_dv=h_act&v_act;
//    tx_hs=h_sync (every line, including blank lines); tx_vs=v_sync for whole lines.
//  - Colours: driven only when tx_dv=1, else 0.
//  - pattern_sel and const_* are latched when (h,v)=(0,0) is issued; mid-frame changes have no effect until next frame.
//  - Solid: latched const_* values.
//  - Bars: bar counter advances every BAR_W pixels and resets per line; order white, yellow, cyan, green, magenta, red, blue, black
//    (components 8'hFF/8'h00). Pixels past 8*BAR_W stay black.
//  - Gradient: R=G=B=h_cnt[7:0] (wraps every 256 px).
//  - Checkerboard: white if ((h_cnt+frame_cnt)[3] ^ v_cnt[3]) else black; 8x8 cells, shifts 1 px per frame.
//  - frame_start=1 together with tx_dv of pixel (0,0) only.
//  - Reset: counters, frame_cnt, latched selections and every output = 0. First pixel (0,0) appears the cycle after
//    the first edge with rst=0 and en=1.
//  - en=0: on the next edge all outputs 0 and counters/frame_cnt cleared. Re-enable restarts at (0,0) with frame_start.
//  - rst mid-frame: same as reset, no partial-line recovery. rst has priority over en.
// TESTING (bench params: H 16/2/2/4, V 4/1/1/2, BAR_W=2; frame = 24x8 = 192 cycles)
//  1. rst 10 cyc, en=1, sel=0, const 11/22/33 -> per line: dv 16 cyc of 11/22/33, then 2 idle, hs 2 cyc, 4 idle.
//     Lines 0-3 active; vs high for all 24 cyc of line 5; frame_start once per 192 cyc.
//  2. sel=1 -> pixel pairs FF/FF/FF, FF/FF/00, 00/FF/FF, 00/FF/00, FF/00/FF, FF/00/00, 00/00/FF, 00/00/00.
//  3. sel=2 -> each active line R=G=B=0..15. sel=3 -> frame 0 line 0: 8x00... no, 8xFF? see rule: pixels 0-7 black, 8-15 white;
//     frame 1 shifts by one pixel.
//  4. Switch sel 0->1 mid-frame -> remaining lines stay solid; bars from next frame_start.
//  5. en=0 mid-line -> next cycle all outputs 0. en=1 -> pixel (0,0) one cycle later with frame_start=1.
//  6. rst=1 mid-frame with en=1 -> outputs 0 next cycle. Release -> frame restarts, frame_cnt=0 (checkerboard unshifted).

Source files
------------

// File: rtl/video_pattern_gen_if.sv
// Pixel-stream bundle between the test-pattern source and its consumer,
// including the run/pattern controls that steer the source.
interface video_pattern_gen_if;
   logic       en;
   logic [1:0] pattern_sel;
   logic [7:0] const_red;
   logic [7:0] const_green;
   logic [7:0] const_blue;
   logic [7:0] tx_red;
   logic [7:0] tx_green;
   logic [7:0] tx_blue;
   logic       tx_dv;
   logic       tx_hs;
   logic       tx_vs;
   logic       frame_start;

   modport master (
      input  en, pattern_sel, const_red, const_green, const_blue,
      output tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start
   );

   modport slave (
      output en, pattern_sel, const_red, const_green, const_blue,
      input  tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start
   );
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing generator with solid / colour-bar / gradient / moving-checkerboard
// test patterns; one pixel per clock, every output registered.
module video_pattern_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int BAR_W    = 160
) (
   input logic                 clk,
   input logic                 rst,
   video_pattern_gen_if.master vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int B_W     = $clog2(BAR_W + 1);

   localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0] V_BIT3     = V_W'(8);
   localparam logic [B_W-1:0] BAR_LAST   = B_W'(BAR_W - 1);

   logic [H_W-1:0] h_cnt_r;
   logic [V_W-1:0] v_cnt_r;
   logic [7:0]     frame_cnt_r;
   logic [B_W-1:0] bar_px_r;
   logic [2:0]     bar_idx_r;
   logic [1:0]     sel_r;
   logic [7:0]     solid_red_r, solid_green_r, solid_blue_r;
   logic [7:0]     tx_red_r, tx_green_r, tx_blue_r;
   logic           tx_dv_r, tx_hs_r, tx_vs_r, frame_start_r;

   logic           h_act_s, v_act_s, h_sync_s, v_sync_s, first_px_s;
   logic [1:0]     sel_s;
   logic [7:0]     solid_red_s, solid_green_s, solid_blue_s;
   logic [7:0]     grad_s;
   logic           chk_white_s;
   logic [23:0]    pix_s;

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] rgb;
      case (idx)
         3'd0:    rgb = 24'hFFFFFF;
         3'd1:    rgb = 24'hFFFF00;
         3'd2:    rgb = 24'h00FFFF;
         3'd3:    rgb = 24'h00FF00;
         3'd4:    rgb = 24'hFF00FF;
         3'd5:    rgb = 24'hFF0000;
         3'd6:    rgb = 24'h0000FF;
         3'd7:    rgb = 24'h000000;
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   // region decode and pattern colour for the pixel at the current counters
   always_comb begin
      h_act_s    = (h_cnt_r < H_ACT_END);
      v_act_s    = (v_cnt_r < V_ACT_END);
      h_sync_s   = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
      v_sync_s   = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);
      first_px_s = (h_cnt_r == {H_W{1'b0}}) && (v_cnt_r == {V_W{1'b0}});
      // pixel (0,0) already uses the live selection that is latched with it
      if (first_px_s) begin
         sel_s         = vid.pattern_sel;
         solid_red_s   = vid.const_red;
         solid_green_s = vid.const_green;
         solid_blue_s  = vid.const_blue;
      end else begin
         sel_s         = sel_r;
         solid_red_s   = solid_red_r;
         solid_green_s = solid_green_r;
         solid_blue_s  = solid_blue_r;
      end
      grad_s      = 8'(h_cnt_r);
      chk_white_s = (|((8'(h_cnt_r) + frame_cnt_r) & 8'h08)) ^ (|(v_cnt_r & V_BIT3));
      case (sel_s)
         2'd0:    pix_s = {solid_red_s, solid_green_s, solid_blue_s};
         2'd1:    pix_s = bar_color(bar_idx_r);
         2'd2:    pix_s = {grad_s, grad_s, grad_s};
         2'd3:    pix_s = chk_white_s ? 24'hFFFFFF : 24'h000000;
         default: pix_s = 24'h000000;
      endcase
   end

   // raster/bar counters, per-frame latched selection and registered outputs
   always_ff @(posedge clk) begin
      if (rst || !vid.en) begin
         h_cnt_r       <= {H_W{1'b0}};
         v_cnt_r       <= {V_W{1'b0}};
         frame_cnt_r   <= 8'h00;
         bar_px_r      <= {B_W{1'b0}};
         bar_idx_r     <= 3'd0;
         sel_r         <= 2'd0;
         solid_red_r   <= 8'h00;
         solid_green_r <= 8'h00;
         solid_blue_r  <= 8'h00;
         tx_red_r      <= 8'h00;
         tx_green_r    <= 8'h00;
         tx_blue_r     <= 8'h00;
         tx_dv_r       <= 1'b0;
         tx_hs_r       <= 1'b0;
         tx_vs_r       <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         tx_dv_r       <= h_act_s & v_act_s;
         {tx_red_r, tx_green_r, tx_blue_r} <= (h_act_s & v_act_s) ? pix_s : 24'h000000;
         tx_hs_r       <= h_sync_s;
         tx_vs_r       <= v_sync_s;
         frame_start_r <= first_px_s;
         if (first_px_s) begin
            sel_r         <= vid.pattern_sel;
            solid_red_r   <= vid.const_red;
            solid_green_r <= vid.const_green;
            solid_blue_r  <= vid.const_blue;
         end
         if (h_cnt_r == H_LAST) begin
            h_cnt_r   <= {H_W{1'b0}};
            bar_px_r  <= {B_W{1'b0}};
            bar_idx_r <= 3'd0;
            if (v_cnt_r == V_LAST) begin
               v_cnt_r     <= {V_W{1'b0}};
               frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
               v_cnt_r <= v_cnt_r + V_W'(1'b1);
            end
         end else begin
            h_cnt_r <= h_cnt_r + H_W'(1'b1);
            // bar index saturates on black so pixels past the eighth bar stay black
            if (bar_px_r == BAR_LAST) begin
               bar_px_r <= {B_W{1'b0}};
               if (bar_idx_r != 3'd7) begin
                  bar_idx_r <= bar_idx_r + 3'd1;
               end
            end else begin
               bar_px_r <= bar_px_r + B_W'(1'b1);
            end
         end
      end
   end

   assign vid.tx_red      = tx_red_r;
   assign vid.tx_green    = tx_green_r;
   assign vid.tx_blue     = tx_blue_r;
   assign vid.tx_dv       = tx_dv_r;
   assign vid.tx_hs       = tx_hs_r;
   assign vid.tx_vs       = tx_vs_r;
   assign vid.frame_start = frame_start_r;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a small 24x8 raster (16/2/2/4, 4/1/1/2, BAR_W=2).
module tb_video_pattern_gen;
   logic clk = 1'b0;
   logic rst;

   video_pattern_gen_if vid();

   video_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(2),
      .BAR_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vid(vid)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  sel;
      int          k;
      logic [27:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [23:0] SOL = 24'h112233;
   localparam logic [23:0] WHT = 24'hFFFFFF;
   localparam logic [23:0] BLK = 24'h000000;

   function automatic logic [27:0] px(input logic [23:0] rgb, input logic dv, input logic hs,
                                      input logic vs, input logic fs);
      return {rgb, dv, hs, vs, fs};
   endfunction

   function automatic void add(input string name, input logic [1:0] sel, input int k,
                               input logic [27:0] exp);
      vec_t v;
      v.name = name;
      v.sel  = sel;
      v.k    = k;
      v.exp  = exp;
      vecs.push_back(v);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [27:0] exp);
      logic [27:0] a;
      a = {vid.tx_red, vid.tx_green, vid.tx_blue, vid.tx_dv, vid.tx_hs, vid.tx_vs, vid.frame_start};
      n_tests++;
      if (a !== exp) begin
         n_fail++;
         $display("FAIL %s: got rgb=%h dv/hs/vs/fs=%b, expected rgb=%h dv/hs/vs/fs=%b",
                  name, a[27:4], a[3:0], exp[27:4], exp[3:0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // after this task pixel k of the fresh frame is visible after tick(k+1)
   task automatic restart(input logic [1:0] sel);
      rst             = 1'b1;
      vid.en          = 1'b1;
      vid.pattern_sel = sel;
      vid.const_red   = 8'h11;
      vid.const_green = 8'h22;
      vid.const_blue  = 8'h33;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      int n_fs, n_vs, n_dv, n_hs;
      rst             = 1'b1;
      vid.en          = 1'b1;
      vid.pattern_sel = 2'd0;
      vid.const_red   = 8'h11;
      vid.const_green = 8'h22;
      vid.const_blue  = 8'h33;
      tick(10);
      check("reset_state", px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));

      add("solid_p00",     2'd0,   0, px(SOL, 1'b1, 1'b0, 1'b0, 1'b1));
      add("solid_p15",     2'd0,  15, px(SOL, 1'b1, 1'b0, 1'b0, 1'b0));
      add("h_fp",          2'd0,  16, px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      add("hs_first",      2'd0,  18, px(BLK, 1'b0, 1'b1, 1'b0, 1'b0));
      add("hs_last",       2'd0,  19, px(BLK, 1'b0, 1'b1, 1'b0, 1'b0));
      add("h_bp",          2'd0,  20, px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      add("solid_l1",      2'd0,  29, px(SOL, 1'b1, 1'b0, 1'b0, 1'b0));
      add("solid_l3_last", 2'd0,  87, px(SOL, 1'b1, 1'b0, 1'b0, 1'b0));
      add("v_fp",          2'd0,  99, px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      add("vs_first",      2'd0, 120, px(BLK, 1'b0, 1'b0, 1'b1, 1'b0));
      add("vs_with_hs",    2'd0, 138, px(BLK, 1'b0, 1'b1, 1'b1, 1'b0));
      add("vs_last",       2'd0, 143, px(BLK, 1'b0, 1'b0, 1'b1, 1'b0));
      add("v_bp",          2'd0, 144, px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      add("frame1_start",  2'd0, 192, px(SOL, 1'b1, 1'b0, 1'b0, 1'b1));
      add("bar_white0",    2'd1,   0, px(WHT, 1'b1, 1'b0, 1'b0, 1'b1));
      add("bar_white1",    2'd1,   1, px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_yellow",    2'd1,   2, px(24'hFFFF00, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_cyan",      2'd1,   5, px(24'h00FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_green",     2'd1,   6, px(24'h00FF00, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_magenta",   2'd1,   9, px(24'hFF00FF, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_red",       2'd1,  10, px(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_blue",      2'd1,  13, px(24'h0000FF, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_black14",   2'd1,  14, px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_black15",   2'd1,  15, px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bar_l1_reset",  2'd1,  27, px(24'hFFFF00, 1'b1, 1'b0, 1'b0, 1'b0));
      add("grad_7",        2'd2,   7, px(24'h070707, 1'b1, 1'b0, 1'b0, 1'b0));
      add("grad_l3_15",    2'd2,  87, px(24'h0F0F0F, 1'b1, 1'b0, 1'b0, 1'b0));
      add("grad_blank",    2'd2,  16, px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      add("chk_f0_p0",     2'd3,   0, px(BLK, 1'b1, 1'b0, 1'b0, 1'b1));
      add("chk_f0_p7",     2'd3,   7, px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f0_p8",     2'd3,   8, px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f0_p15",    2'd3,  15, px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f1_p6",     2'd3, 198, px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f1_p7",     2'd3, 199, px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f1_p15",    2'd3, 207, px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      add("chk_f2_p6",     2'd3, 390, px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));

      foreach (vecs[i]) begin
         restart(vecs[i].sel);
         tick(vecs[i].k + 1);
         check(vecs[i].name, vecs[i].exp);
      end

      // two full frames: pulse and sync-width totals
      restart(2'd0);
      n_fs = 0; n_vs = 0; n_dv = 0; n_hs = 0;
      for (int k = 0; k < 384; k++) begin
         tick(1);
         n_fs += int'(vid.frame_start);
         n_vs += int'(vid.tx_vs);
         n_dv += int'(vid.tx_dv);
         n_hs += int'(vid.tx_hs);
      end
      check_int("frame_start_count", n_fs, 2);
      check_int("vs_cycle_count", n_vs, 48);
      check_int("dv_cycle_count", n_dv, 128);
      check_int("hs_cycle_count", n_hs, 32);

      // mid-frame pattern switch takes effect at the next frame
      restart(2'd0);
      tick(31);
      vid.pattern_sel = 2'd1;
      tick(20);
      check("sel_hold_mid", px(SOL, 1'b1, 1'b0, 1'b0, 1'b0));
      tick(142);
      check("sel_new_frame", px(WHT, 1'b1, 1'b0, 1'b0, 1'b1));
      tick(2);
      check("sel_new_bar1", px(24'hFFFF00, 1'b1, 1'b0, 1'b0, 1'b0));

      // en drop mid-line blanks next cycle; re-enable restarts at (0,0)
      restart(2'd0);
      tick(6);
      vid.en = 1'b0;
      tick(1);
      check("en_off", px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      tick(3);
      check("en_off_hold", px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      vid.en = 1'b1;
      tick(1);
      check("en_restart", px(SOL, 1'b1, 1'b0, 1'b0, 1'b1));
      tick(1);
      check("en_restart_p1", px(SOL, 1'b1, 1'b0, 1'b0, 1'b0));

      // reset mid-frame clears frame_cnt so the checkerboard is unshifted again
      restart(2'd3);
      tick(201);
      check("chk_f1_p8", px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));
      rst = 1'b1;
      tick(1);
      check("rst_mid", px(BLK, 1'b0, 1'b0, 1'b0, 1'b0));
      rst = 1'b0;
      tick(1);
      check("rst_restart", px(BLK, 1'b1, 1'b0, 1'b0, 1'b1));
      tick(7);
      check("rst_chk_p7", px(BLK, 1'b1, 1'b0, 1'b0, 1'b0));
      tick(1);
      check("rst_chk_p8", px(WHT, 1'b1, 1'b0, 1'b0, 1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
